// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits a programmed number of A/B edges at a fixed interval.
// Optional index output Z is built when macro QEG_INDEX_EN is defined.
module quad_encoder_gen #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic [N-1:0] steps,
  input  logic [N-1:0] period,
  output logic         A,
  output logic         B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] remaining,
`ifdef QEG_INDEX_EN
  output logic [N-1:0] position,
  output logic         Z
`else
  output logic [N-1:0] position
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_dir;
  logic [N-1:0] r_period;
  logic [N-1:0] r_timer;

  logic         w_accept;
  logic         w_edge;
  logic         w_dir_nxt;
  logic [N-1:0] w_period_nxt;
  logic [N-1:0] w_timer_nxt;
  logic [N-1:0] w_remaining_nxt;
  logic [N-1:0] w_position_nxt;
  logic         w_a_nxt;
  logic         w_b_nxt;
  logic         w_busy_nxt;
  logic         w_done_nxt;
`ifdef QEG_INDEX_EN
  logic         w_z_nxt;
`endif

  assign w_accept = (r_state == S_IDLE) && start;
  // r_period is never 0, so the interval timer wraps at r_period-1
  assign w_edge   = (r_state == S_RUN) && (r_timer == (r_period - N'(1)));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (steps == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_edge && (remaining == N'(1))) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and run context
  always_comb begin
    w_dir_nxt       = r_dir;
    w_period_nxt    = r_period;
    w_timer_nxt     = r_timer;
    w_remaining_nxt = remaining;
    w_position_nxt  = position;
    w_a_nxt         = A;
    w_b_nxt         = B;
    w_busy_nxt      = (r_state == S_RUN) || w_accept;
    w_done_nxt      = (r_state == S_FIN);
`ifdef QEG_INDEX_EN
    w_z_nxt         = 1'b0;
`endif

    if (w_accept) begin
      w_dir_nxt       = dir;
      w_period_nxt    = (period == '0) ? N'(1) : period;
      w_timer_nxt     = '0;
      w_remaining_nxt = steps;
    end else if (r_state == S_RUN) begin
      w_timer_nxt = w_edge ? '0 : (r_timer + N'(1));
    end

    if (w_edge) begin
      w_remaining_nxt = remaining - N'(1);
      w_position_nxt  = r_dir ? (position + N'(1)) : (position - N'(1));
      // Gray step: CW toggles A when A==B, CCW toggles B when A==B
      if ((A == B) == r_dir) begin
        w_a_nxt = ~A;
      end else begin
        w_b_nxt = ~B;
      end
`ifdef QEG_INDEX_EN
      w_z_nxt = (w_position_nxt == '0);
`endif
    end
  end

  // Output and context registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir     <= 1'b0;
      r_period  <= N'(1);
      r_timer   <= '0;
      remaining <= '0;
      position  <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef QEG_INDEX_EN
      Z         <= 1'b0;
`endif
    end else begin
      r_dir     <= w_dir_nxt;
      r_period  <= w_period_nxt;
      r_timer   <= w_timer_nxt;
      remaining <= w_remaining_nxt;
      position  <= w_position_nxt;
      A         <= w_a_nxt;
      B         <= w_b_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
`ifdef QEG_INDEX_EN
      Z         <= w_z_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Randomized self-checking bench for quad_encoder_gen against a timeline model of each run.
// Checks index output Z too when QEG_INDEX_EN is defined.
module tb_quad_encoder_gen;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         dir;
  logic [N-1:0] steps;
  logic [N-1:0] period;
  logic         A;
  logic         B;
  logic         busy;
  logic         done;
  logic [N-1:0] remaining;
  logic [N-1:0] position;
`ifdef QEG_INDEX_EN
  logic         Z;
`endif

  quad_encoder_gen #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .steps     (steps),
    .period    (period),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
`ifdef QEG_INDEX_EN
    .position  (position),
    .Z         (Z)
`else
    .position  (position)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Run model: a run is fully described by its accept cycle, step count and interval
  int        cyc     = 0;
  bit        m_run   = 1'b0;
  int        m_c0    = 0;
  int        m_steps = 0;
  int        m_p     = 1;
  int        m_len   = 0;
  bit        m_dir   = 1'b0;
  logic [7:0] m_pos0 = 8'd0;
  int        m_ph0   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pos_after(input int k);
    return m_dir ? (m_pos0 + 8'(k)) : (m_pos0 - 8'(k));
  endfunction

  // Phase index: 0=AB00, 1=AB10, 2=AB11, 3=AB01; CW counts up, CCW counts down
  function automatic int ph_after(input int k);
    return (((m_ph0 + (m_dir ? k : -k)) % 4) + 4) % 4;
  endfunction

  task automatic check_outputs();
    int e;
    int k;
    int ph;
    bit exp_busy;
    bit exp_done;
    bit exp_edge;
    int exp_rem;
    logic [7:0] exp_pos;
    k        = 0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_edge = 1'b0;
    exp_rem  = 0;
    if (m_run) begin
      e = cyc - m_c0;
      k = e / m_p;
      if (k > m_steps) k = m_steps;
      exp_busy = (e <= m_len);
      exp_done = (e == m_len + 1);
      exp_rem  = m_steps - k;
      exp_edge = (e > 0) && (e % m_p == 0) && (e / m_p <= m_steps);
    end
    exp_pos = pos_after(k);
    ph      = ph_after(k);
    check("A", 32'(A), 32'((ph == 1) || (ph == 2)));
    check("B", 32'(B), 32'(ph >= 2));
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("remaining", 32'(remaining), 32'(exp_rem));
    check("position", 32'(position), 32'(exp_pos));
`ifdef QEG_INDEX_EN
    check("Z", 32'(Z), 32'(exp_edge && (exp_pos == 8'd0)));
`endif
  endtask

  task automatic tick(input bit s, input bit d, input int st, input int pr);
    @(negedge clk);
    start  = s;
    dir    = d;
    steps  = N'(st);
    period = N'(pr);
    @(posedge clk);
    cyc++;
    if (s && (!m_run || (cyc >= m_c0 + m_len + 2))) begin
      if (m_run) begin
        m_pos0 = pos_after(m_steps);
        m_ph0  = ph_after(m_steps);
      end
      m_run   = 1'b1;
      m_c0    = cyc;
      m_steps = st;
      m_p     = (pr == 0) ? 1 : pr;
      m_len   = st * m_p;
      m_dir   = d;
    end
    #1;
    start = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_A", 32'(A), 32'd0);
    check("rst_B", 32'(B), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_position", 32'(position), 32'd0);
`ifdef QEG_INDEX_EN
    check("rst_Z", 32'(Z), 32'd0);
`endif
    m_run  = 1'b0;
    m_pos0 = 8'd0;
    m_ph0  = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    dir    = 1'b0;
    steps  = '0;
    period = '0;
    #1;
    check("init_busy", 32'(busy), 32'd0);
    check("init_position", 32'(position), 32'd0);
    check("init_AB", 32'({A, B}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // CW, 4 steps every 3 cycles
    tick(1'b1, 1'b1, 4, 3);
    idle(14);
    check("cw_position", 32'(position), 32'd4);
    check("cw_AB", 32'({A, B}), 32'd0);

    // CCW, 6 steps back to back, wraps below zero
    tick(1'b1, 1'b0, 6, 1);
    idle(8);
    check("ccw_position", 32'(position), 32'd254);
    check("ccw_AB", 32'({A, B}), 32'b11);

    // Zero-step run and period 0 acting as 1
    tick(1'b1, 1'b1, 0, 5);
    idle(3);
    tick(1'b1, 1'b1, 1, 0);
    idle(3);

    // Restart attempts during a run are ignored
    tick(1'b1, 1'b1, 2, 2);
    tick(1'b1, 1'b0, 9, 1);
    tick(1'b1, 1'b0, 9, 1);
    tick(1'b1, 1'b0, 9, 1);
    idle(4);
    check("ignore_position", 32'(position), 32'd1);

    // From position 1, CCW edges hit 0 then 255
    tick(1'b1, 1'b0, 2, 1);
    idle(4);
    check("idx_position", 32'(position), 32'd255);

    // Reset mid-run after two of five edges
    tick(1'b1, 1'b1, 5, 2);
    idle(4);
    check("mid_remaining", 32'(remaining), 32'd3);
    do_reset();
    idle(12);

    // Random traffic, including starts during runs
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      if (i == 300) begin
        do_reset();
      end
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_gen.md
QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 SHALL have parameter N, default 8: width of steps, period, remaining and position.
REQ-002 SHALL have port clk, input, 1: system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a run.
REQ-005 SHALL have port dir, input, 1: 1 = CW (A leads B), 0 = CCW (B leads A); sampled with start.
REQ-006 SHALL have port steps, input, N: quadrature edges to emit; sampled with start.
REQ-007 SHALL have port period, input, N: clk cycles between edges; sampled with start.
REQ-008 SHALL have port A, output, 1: emulated encoder channel A, registered.
REQ-009 SHALL have port B, output, 1: emulated encoder channel B, registered.
REQ-010 SHALL have port busy, output, 1: high while a run is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at run completion.
REQ-012 SHALL have port remaining, output, N: edges still to emit in current run.
REQ-013 SHALL have port position, output, N: signed-wrap edge count, +1 per CW edge, -1 per CCW edge.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIN; IDLE -> RUN on start; RUN -> FIN when remaining reaches 0; FIN -> IDLE after one cycle.
REQ-015 SHALL accept start only in IDLE; start in RUN or FIN is ignored, with no effect on inputs latched.
REQ-016 SHALL, on accepted start, latch dir, steps and period, load remaining = steps, clear the interval timer, and assert busy the next cycle.
REQ-017 SHALL, with steps = 0, go IDLE -> FIN -> IDLE: no edge emitted, busy high one cycle, done one cycle later.
REQ-018 SHALL treat period = 0 as period = 1.
REQ-019 SHALL emit the first edge exactly period cycles after the cycle start is accepted, then one edge every period cycles.
REQ-020 SHALL advance the CW phase sequence AB 00 -> 10 -> 11 -> 01 -> 00 and the CCW sequence 00 -> 01 -> 11 -> 10 -> 00; exactly one of A/B toggles per edge.
REQ-021 SHALL keep the AB phase across runs; a new run continues from the current phase and never resets it to 00.
REQ-022 SHALL decrement remaining and update position in the same cycle as each edge; position wraps modulo 2^N in both directions.
REQ-023 SHALL deassert busy and pulse done for one cycle in FIN; done is never high while busy is high.

Reset
REQ-024 SHALL, on reset, force state IDLE, A = 0, B = 0, busy = 0, done = 0, remaining = 0, position = 0, timer = 0, immediately, without waiting for clk.
REQ-025 SHALL, on reset asserted mid-run, abandon the run with no done pulse; after release, remain in IDLE until the next start.

Configuration
REQ-026 SHALL, with macro QEG_INDEX_EN defined, add output Z (1 bit, reset 0) pulsing high for one clk cycle in the cycle an edge makes position equal 0, in either direction.
REQ-027 SHALL, with QEG_INDEX_EN undefined, have no Z port and no index logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: reset, then start with dir=1, steps=4, period=3 -> AB 10, 11, 01, 00 at 3, 6, 9 and 12 cycles after start; position=4; done one cycle after the 4th edge.
REQ-029 SHALL cover: from AB=00 and position=4, start with dir=0, steps=6, period=1 -> AB 01, 11, 10, 00, 01, 11 on consecutive cycles; position=254 (N=8).
REQ-030 SHALL cover: start with steps=0 -> no A/B change; busy high one cycle; done one cycle later; remaining=0.
REQ-031 SHALL cover: start pulsed again during RUN with steps=9 -> ignored; the original run completes with its latched steps.
REQ-032 SHALL cover: reset asserted after 2 of 5 edges -> A=B=0, position=0 and busy=0 immediately; done never pulses.
REQ-033 SHALL cover: with QEG_INDEX_EN defined, position=1, start dir=0, steps=2 -> Z high for exactly one cycle on the first edge; not on the second edge (position=255).
